// File: rtl/branch_flag_pkg.sv
// ============================================================================
// Module      : branch_flag_pkg
// Description : Condition codes, FSM encoding, flag bit indices and branch
//               condition helpers shared by the branch flag unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_flag_pkg;

    localparam logic [3:0] COND_BR   = 4'd0;
    localparam logic [3:0] COND_BLTZ = 4'd1;
    localparam logic [3:0] COND_BZ   = 4'd2;
    localparam logic [3:0] COND_BNZ  = 4'd3;
    localparam logic [3:0] COND_BCY  = 4'd4;
    localparam logic [3:0] COND_BNCY = 4'd5;
    localparam logic [3:0] COND_BS   = 4'd6;
    localparam logic [3:0] COND_BNS  = 4'd7;
    localparam logic [3:0] COND_BV   = 4'd8;
    localparam logic [3:0] COND_BNV  = 4'd9;
    localparam logic [3:0] COND_CALL = 4'd10;
    localparam logic [3:0] COND_RET  = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_flag_cond(input logic [3:0] cond);
        return (cond >= COND_BCY) && (cond <= COND_BNV);
    endfunction

    function automatic logic cond_taken(input logic [3:0]  cond,
                                        input logic [3:0]  flags,
                                        input logic [31:0] rs);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_BR:   taken = 1'b1;
            COND_BLTZ: taken = rs[31];
            COND_BZ:   taken = (rs == 32'd0);
            COND_BNZ:  taken = (rs != 32'd0);
            COND_BCY:  taken = flags[FLAG_C];
            COND_BNCY: taken = !flags[FLAG_C];
            COND_BS:   taken = flags[FLAG_S];
            COND_BNS:  taken = !flags[FLAG_S];
            COND_BV:   taken = flags[FLAG_V];
            COND_BNV:  taken = !flags[FLAG_V];
            COND_CALL: taken = 1'b1;
            COND_RET:  taken = 1'b1;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_flag_unit_if.sv
// ============================================================================
// Module      : branch_flag_unit_if
// Description : Branch request / resolution handshake between decode and the
//               branch flag unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_flag_unit_if #(
    parameter int ADDR_W = 32
);
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_target;
    logic [31:0]       br_rs_val;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic [ADDR_W-1:0] res_next_pc;
    logic              res_link_valid;
    logic [ADDR_W-1:0] res_link;

    modport master (
        output br_valid, br_cond, br_pc, br_target, br_rs_val, res_ready,
        input  br_ready, res_valid, res_taken, res_next_pc, res_link_valid, res_link
    );

    modport slave (
        input  br_valid, br_cond, br_pc, br_target, br_rs_val, res_ready,
        output br_ready, res_valid, res_taken, res_next_pc, res_link_valid, res_link
    );
endinterface

`default_nettype wire

// File: rtl/return_addr_stack.sv
// ============================================================================
// Module      : return_addr_stack
// Description : Circular return-address stack; a push when full overwrites the
//               oldest entry. Built only when BRANCH_FLAG_RAS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef BRANCH_FLAG_RAS_EN
module return_addr_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_next_ptr;

    // r_wr_ptr is the next free slot; the top lives one slot behind it
    assign w_top_idx  = (r_wr_ptr == '0) ? PTR_W'(DEPTH - 1) : r_wr_ptr - PTR_W'(1);
    assign w_next_ptr = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign top        = r_mem[w_top_idx];
    assign empty      = (r_count == '0);
    assign full       = (r_count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (push) begin
            r_wr_ptr <= w_next_ptr;
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_wr_ptr <= w_top_idx;
            r_count  <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end
endmodule
`endif

`default_nettype wire

// File: rtl/branch_flag_unit.sv
// ============================================================================
// Module      : branch_flag_unit
// Description : Architectural flag register plus KGP-RISC branch resolver with
//               flag-writer interlock. Optional RAS via BRANCH_FLAG_RAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_flag_unit
    import branch_flag_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PEND_W    = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flag_pend_set,
    input  logic                flag_wr_en,
    input  logic [3:0]          flag_in,
    output logic [3:0]          flags_q,
    branch_flag_unit_if.slave   bus
);
    logic [1:0]        r_state;
    logic [3:0]        r_cond;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic [31:0]       r_rs;
    logic [3:0]        r_flags;
    logic [PEND_W-1:0] r_pend_cnt;
    logic              r_res_taken;
    logic [ADDR_W-1:0] r_res_next_pc;
    logic              r_res_link_valid;
    logic [ADDR_W-1:0] r_res_link;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic              w_stall;
    logic              w_eval;
    logic              w_taken;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_ret_from_ras;
    logic [ADDR_W-1:0] w_ras_top;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    // A flag write in the same cycle also stalls, so the new value is used
    assign w_stall    = is_flag_cond(r_cond) && ((r_pend_cnt != '0) || flag_wr_en);
    assign w_eval     = (r_state == ST_WAIT) && !w_stall;
    assign w_taken    = cond_taken(r_cond, r_flags, r_rs);

`ifdef BRANCH_FLAG_RAS_EN
    logic w_ras_empty;
    logic w_ras_full;

    return_addr_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_eval && (r_cond == COND_CALL)),
        .pop       (w_eval && (r_cond == COND_RET)),
        .push_data (w_pc_plus4),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    assign w_ret_from_ras = !w_ras_empty;
`else
    assign w_ret_from_ras = 1'b0;
    assign w_ras_top      = '0;
`endif

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (r_cond == COND_RET) begin
            w_next_pc = w_ret_from_ras ? w_ras_top : r_rs[ADDR_W-1:0];
        end else if (w_taken) begin
            w_next_pc = r_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cond           <= '0;
            r_pc             <= '0;
            r_target         <= '0;
            r_rs             <= '0;
            r_flags          <= '0;
            r_pend_cnt       <= '0;
            r_res_taken      <= 1'b0;
            r_res_next_pc    <= '0;
            r_res_link_valid <= 1'b0;
            r_res_link       <= '0;
        end else begin
            if (flag_wr_en) begin
                r_flags <= flag_in;
            end

            // Saturate at both ends: overflow is a protocol error, underflow an untracked writer
            case ({flag_pend_set, flag_wr_en})
                2'b10: if (r_pend_cnt != {PEND_W{1'b1}}) r_pend_cnt <= r_pend_cnt + PEND_W'(1);
                2'b01: if (r_pend_cnt != '0)             r_pend_cnt <= r_pend_cnt - PEND_W'(1);
                default: ;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (bus.br_valid) begin
                        r_cond   <= bus.br_cond;
                        r_pc     <= bus.br_pc;
                        r_target <= bus.br_target;
                        r_rs     <= bus.br_rs_val;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_eval) begin
                        r_res_taken      <= w_taken;
                        r_res_next_pc    <= w_next_pc;
                        r_res_link_valid <= (r_cond == COND_CALL);
                        r_res_link       <= (r_cond == COND_CALL) ? w_pc_plus4 : '0;
                        r_state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign flags_q            = r_flags;
    assign bus.br_ready       = (r_state == ST_IDLE);
    assign bus.res_valid      = (r_state == ST_RESP);
    assign bus.res_taken      = r_res_taken;
    assign bus.res_next_pc    = r_res_next_pc;
    assign bus.res_link_valid = r_res_link_valid;
    assign bus.res_link       = r_res_link;
endmodule

`default_nettype wire

// File: tb/tb_branch_flag_unit.sv
// ============================================================================
// Module      : tb_branch_flag_unit
// Description : Directed self-checking bench for branch_flag_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_flag_unit;
    import branch_flag_pkg::*;

    logic       clk;
    logic       rst;
    logic       flag_pend_set;
    logic       flag_wr_en;
    logic [3:0] flag_in;
    logic [3:0] flags_q;

    int total;
    int bad;

    branch_flag_unit_if #(.ADDR_W(32)) bus ();

    branch_flag_unit #(
        .ADDR_W    (32),
        .PEND_W    (2),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flag_pend_set (flag_pend_set),
        .flag_wr_en    (flag_wr_en),
        .flag_in       (flag_in),
        .flags_q       (flags_q),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request once br_ready is seen; returns just after the accept edge
    task automatic send(input logic [3:0] c, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] rs);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.br_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: br_ready=%0b required 1", bus.br_ready);
        end
        bus.br_valid  = 1'b1;
        bus.br_cond   = c;
        bus.br_pc     = pc;
        bus.br_target = tgt;
        bus.br_rs_val = rs;
        @(posedge clk); #1;
        bus.br_valid  = 1'b0;
    endtask

    // Edges from accept until res_valid; 20 means timed out
    task automatic wait_res(output int n);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.br_valid = 1'b1;
        bus.br_cond  = COND_BR;
        bus.br_pc    = 32'h100;
        bus.br_target = 32'h200;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.res_taken !== 1'b0 || bus.res_next_pc !== 32'h0 ||
            bus.res_link_valid !== 1'b0 || bus.res_link !== 32'h0 || flags_q !== 4'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0b taken=%0b npc=%h lv=%0b link=%h flags=%h required all 0",
                     bus.res_valid, bus.res_taken, bus.res_next_pc, bus.res_link_valid, bus.res_link, flags_q);
        end
        total++;
        if (bus.br_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: br_ready=%0b required 1", bus.br_ready);
        end
        bus.br_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_br();
        int n;
        send(COND_BR, 32'h100, 32'h200, 32'h0);
        total++;
        if (bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL br_early_valid: res_valid=%0b required 0", bus.res_valid);
        end
        wait_res(n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL br_latency: edges=%0d required 1", n);
        end
        total++;
        if (bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h200 || bus.res_link_valid !== 1'b0) begin
            bad++;
            $display("FAIL br_result: taken=%0b npc=%h lv=%0b required 1 00000200 0",
                     bus.res_taken, bus.res_next_pc, bus.res_link_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flag_cond();
        int n;
        flag_wr_en = 1'b1;
        flag_in    = 4'b0100;
        @(posedge clk); #1;
        flag_wr_en = 1'b0;
        total++;
        if (flags_q !== 4'b0100) begin
            bad++;
            $display("FAIL flag_write: flags=%b required 0100", flags_q);
        end
        send(COND_BCY, 32'h40, 32'h80, 32'h0);
        wait_res(n);
        total++;
        if (n != 1 || bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h80) begin
            bad++;
            $display("FAIL bcy: edges=%0d taken=%0b npc=%h required 1 1 00000080", n, bus.res_taken, bus.res_next_pc);
        end
        @(posedge clk); #1;
        send(COND_BNCY, 32'h40, 32'h80, 32'h0);
        wait_res(n);
        total++;
        if (n != 1 || bus.res_taken !== 1'b0 || bus.res_next_pc !== 32'h44) begin
            bad++;
            $display("FAIL bncy: edges=%0d taken=%0b npc=%h required 1 0 00000044", n, bus.res_taken, bus.res_next_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit stalled_ok;
        flag_pend_set = 1'b1;
        @(posedge clk); #1;
        flag_pend_set = 1'b0;
        send(COND_BV, 32'h10, 32'h60, 32'h0);
        stalled_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (bus.br_ready !== 1'b0 || bus.res_valid !== 1'b0) stalled_ok = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!stalled_ok || bus.br_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: br_ready=%0b res_valid=%0b required 0 0 throughout", bus.br_ready, bus.res_valid);
        end
        flag_wr_en = 1'b1;
        flag_in    = 4'b0001;
        @(posedge clk); #1;
        flag_wr_en = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || flags_q !== 4'b0001) begin
            bad++;
            $display("FAIL stall_wr_cycle: res_valid=%0b flags=%b required 0 0001", bus.res_valid, flags_q);
        end
        @(posedge clk); #1;
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h60) begin
            bad++;
            $display("FAIL stall_release: valid=%0b taken=%0b npc=%h required 1 1 00000060",
                     bus.res_valid, bus.res_taken, bus.res_next_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rs_cond();
        // flags are now {z,c,s,v} = 0001
        logic [3:0]  c_tab   [8] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd14, 4'd4, 4'd9};
        logic [31:0] pc_tab  [8] = '{32'h1000, 32'h1000, 32'h1100, 32'h1200, 32'h1200, 32'h1300, 32'hFFFFFFFC, 32'h1400};
        logic [31:0] tg_tab  [8] = '{32'h2000, 32'h2000, 32'h2100, 32'h2200, 32'h2200, 32'h2300, 32'h10, 32'h2400};
        logic [31:0] rs_tab  [8] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0};
        logic        tk_tab  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] np_tab  [8] = '{32'h2000, 32'h1004, 32'h2100, 32'h1204, 32'h2200, 32'h1304, 32'h0, 32'h1404};
        int n;
        for (int i = 0; i < 8; i++) begin
            send(c_tab[i], pc_tab[i], tg_tab[i], rs_tab[i]);
            wait_res(n);
            total++;
            if (n != 1 || bus.res_taken !== tk_tab[i] || bus.res_next_pc !== np_tab[i] ||
                bus.res_link_valid !== 1'b0 || bus.res_link !== 32'h0) begin
                bad++;
                $display("FAIL cond_vec%0d: edges=%0d taken=%0b npc=%h lv=%0b link=%h required 1 %0b %h 0 00000000",
                         i, n, bus.res_taken, bus.res_next_pc, bus.res_link_valid, bus.res_link, tk_tab[i], np_tab[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_call_ret();
        int n;
        logic [31:0] exp_ret;
`ifdef BRANCH_FLAG_RAS_EN
        exp_ret = 32'h304;
`else
        exp_ret = 32'h999;
`endif
        send(COND_CALL, 32'h300, 32'h500, 32'h0);
        wait_res(n);
        total++;
        if (n != 1 || bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h500 ||
            bus.res_link_valid !== 1'b1 || bus.res_link !== 32'h304) begin
            bad++;
            $display("FAIL call: edges=%0d taken=%0b npc=%h lv=%0b link=%h required 1 1 00000500 1 00000304",
                     n, bus.res_taken, bus.res_next_pc, bus.res_link_valid, bus.res_link);
        end
        @(posedge clk); #1;
        send(COND_RET, 32'h700, 32'h0, 32'h999);
        wait_res(n);
        total++;
        if (n != 1 || bus.res_taken !== 1'b1 || bus.res_next_pc !== exp_ret || bus.res_link_valid !== 1'b0) begin
            bad++;
            $display("FAIL ret: edges=%0d taken=%0b npc=%h lv=%0b required 1 1 %h 0",
                     n, bus.res_taken, bus.res_next_pc, bus.res_link_valid, exp_ret);
        end
        @(posedge clk); #1;
        send(COND_RET, 32'h710, 32'h0, 32'h888);
        wait_res(n);
        total++;
        if (n != 1 || bus.res_next_pc !== 32'h888) begin
            bad++;
            $display("FAIL ret_empty: edges=%0d npc=%h required 1 00000888", n, bus.res_next_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int n;
        bit stable;
        bus.res_ready = 1'b0;
        send(COND_BR, 32'h900, 32'hA00, 32'h0);
        wait_res(n);
        stable = (n == 1);
        for (int i = 0; i < 5; i++) begin
            if (bus.res_valid !== 1'b1 || bus.br_ready !== 1'b0 || bus.res_taken !== 1'b1 ||
                bus.res_next_pc !== 32'hA00) stable = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!stable || bus.res_valid !== 1'b1 || bus.res_next_pc !== 32'hA00) begin
            bad++;
            $display("FAIL hold_stable: valid=%0b ready=%0b npc=%h required 1 0 00000A00",
                     bus.res_valid, bus.br_ready, bus.res_next_pc);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.br_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: valid=%0b ready=%0b required 0 1", bus.res_valid, bus.br_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        bit quiet;
        flag_pend_set = 1'b1;
        @(posedge clk); #1;
        flag_pend_set = 1'b0;
        send(COND_BV, 32'h20, 32'h90, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.br_ready !== 1'b1 || flags_q !== 4'h0) begin
            bad++;
            $display("FAIL reset_wait: valid=%0b ready=%0b flags=%h required 0 1 0",
                     bus.res_valid, bus.br_ready, flags_q);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL reset_discard: res_valid seen after reset, required 0");
        end
        // pending count was cleared, so a flag branch resolves without stalling
        send(COND_BNV, 32'h30, 32'hB0, 32'h0);
        wait_res(n);
        total++;
        if (n != 1 || bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'hB0) begin
            bad++;
            $display("FAIL post_reset_bnv: edges=%0d taken=%0b npc=%h required 1 1 000000B0",
                     n, bus.res_taken, bus.res_next_pc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        flag_pend_set = 1'b0;
        flag_wr_en    = 1'b0;
        flag_in       = 4'h0;
        bus.br_valid  = 1'b0;
        bus.br_cond   = 4'h0;
        bus.br_pc     = 32'h0;
        bus.br_target = 32'h0;
        bus.br_rs_val = 32'h0;
        bus.res_ready = 1'b1;

        test_reset();
        test_br();
        test_flag_cond();
        test_stall();
        test_rs_cond();
        test_call_ret();
        test_hold();
        test_reset_in_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
